// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator with run/stop control.
// Ports: clk, rst_n (sync, active-low), en in; hsync, vsync, de, x, y,
//        line_start, frame_start, busy out -- all registered, 1-clock latency.
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        line_start,
    output logic        frame_start,
    output logic        busy
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_size_chk
            $error("video_timing_gen: H_TOTAL/V_TOTAL exceed 4096");
        end
    endgenerate

    // 13-bit bounds so a region edge of exactly 4096 stays representable
    localparam logic [12:0] H_ACT  = 13'(H_ACTIVE);
    localparam logic [12:0] H_SS   = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] H_SE   = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] H_LAST = 13'(H_TOTAL - 1);
    localparam logic [12:0] V_ACT  = 13'(V_ACTIVE);
    localparam logic [12:0] V_SS   = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] V_SE   = 13'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [12:0] V_LAST = 13'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;

    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        de_q, de_d;
    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;
    logic        busy_q, busy_d;

    logic [12:0] h13, v13;
    logic        h_last, v_last, running;

    always_comb begin
        h13     = {1'b0, h_cnt_q};
        v13     = {1'b0, v_cnt_q};
        h_last  = (h13 == H_LAST);
        v_last  = (v13 == V_LAST);
        running = (state_q != IDLE);

        state_d = state_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;

        case (state_q)
            IDLE: begin
                h_cnt_d = '0;
                v_cnt_d = '0;
                if (en) state_d = RUN;
            end
            RUN, STOP: begin
                if (h_last) begin
                    h_cnt_d = '0;
                    v_cnt_d = v_last ? 12'd0 : v_cnt_q + 12'd1;
                end else begin
                    h_cnt_d = h_cnt_q + 12'd1;
                end
                // a frame only ends at the final wrap; en decides what follows
                if (h_last && v_last) state_d = en ? RUN : IDLE;
                else                  state_d = en ? RUN : STOP;
            end
            default: state_d = IDLE;
        endcase

        // outputs describe the current counter position, registered once
        de_d = running && (h13 < H_ACT) && (v13 < V_ACT);
        hsync_d = (running && h13 >= H_SS && h13 < H_SE) ? HS_POL : ~HS_POL;
        vsync_d = (running && v13 >= V_SS && v13 < V_SE) ? VS_POL : ~VS_POL;
        x_d = de_d ? h_cnt_q : 12'd0;
        y_d = de_d ? v_cnt_q : 12'd0;
        line_start_d  = running && (h_cnt_q == 12'd0);
        frame_start_d = line_start_d && (v_cnt_q == 12'd0);
        busy_d = running;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: scoreboard bench for video_timing_gen (small raster).
// Raster 7x5 clocks: H 4/1/1/1, V 2/1/1/1, sync polarity active-high.
module tb_video_timing_gen;
    localparam int HT = 7;
    localparam int VT = 5;
    localparam int FT = HT * VT;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] x;
        logic [11:0] y;
        logic        ls;
        logic        fs;
        logic        busy;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        hsync, vsync, de, line_start, frame_start, busy;
    logic [11:0] x, y;

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .hsync(hsync), .vsync(vsync), .de(de),
        .x(x), .y(y),
        .line_start(line_start), .frame_start(frame_start),
        .busy(busy)
    );

    always #5 clk = ~clk;

    obs_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   m_st = 0;  // 0 idle, 1 run, 2 stop
    int   m_p = 0;   // linear position in frame: v*HT + h

    // Hand-derived: sync at h=5 (4+1), v=3 (2+1); idle syncs are 0.
    function automatic obs_t expect_out(int st, int p);
        obs_t o;
        int h, v;
        o = '0;
        if (st != 0) begin
            h = p % HT;
            v = p / HT;
            o.hs = (h == 5);
            o.vs = (v == 3);
            o.de = (h < 4) && (v < 2);
            o.x = o.de ? 12'(h) : 12'd0;
            o.y = o.de ? 12'(v) : 12'd0;
            o.ls = (h == 0);
            o.fs = (p == 0);
            o.busy = 1'b1;
        end
        return o;
    endfunction

    task automatic step(input logic r, input logic e);
        rst_n = r;
        en = e;
        @(posedge clk);
        if (!r) begin
            exp_q.push_back('0);
            m_st = 0;
            m_p = 0;
        end else begin
            exp_q.push_back(expect_out(m_st, m_p));
            if (m_st == 0) begin
                if (e) m_st = 1;
            end else if (m_p == FT - 1) begin
                m_p = 0;
                m_st = e ? 1 : 0;
            end else begin
                m_p++;
                m_st = e ? 1 : 2;
            end
        end
        #1;
    endtask

    task automatic run_to(input logic e, input int target);
        for (int i = 0; i < 4 * FT && m_p != target; i++) step(1'b1, e);
    endtask

    int cyc = 0;
    int last_fs = -1;

    always @(negedge clk) begin : monitor
        obs_t got;
        obs_t want;
        cyc++;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got = {hsync, vsync, de, x, y, line_start, frame_start, busy};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL outputs cyc=%0d got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b busy=%b want hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b busy=%b",
                    cyc, got.hs, got.vs, got.de, got.x, got.y, got.ls, got.fs, got.busy,
                    want.hs, want.vs, want.de, want.x, want.y, want.ls, want.fs, want.busy);
            end
            if (busy !== 1'b1) last_fs = -1;
            if (frame_start === 1'b1) begin
                if (last_fs >= 0) begin
                    total++;
                    if (cyc - last_fs != FT) begin
                        bad++;
                        $display("FAIL fs_period got=%0d want=%0d", cyc - last_fs, FT);
                    end
                end
                last_fs = cyc;
            end
        end
    end

    initial begin
        repeat (3) step(1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0);
        // three back-to-back frames plus wrap
        repeat (3 * FT + 2) step(1'b1, 1'b1);
        // drop en mid-frame: frame completes, then idle
        run_to(1'b1, HT + 1);
        repeat (FT + 4) step(1'b1, 1'b0);
        // restart, then re-request during STOP in the last line
        repeat (3) step(1'b1, 1'b1);
        run_to(1'b1, 4 * HT + 1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        repeat (FT) step(1'b1, 1'b1);
        // reset at x=3, y=1, then restart with en held
        run_to(1'b1, HT + 3);
        step(1'b0, 1'b1);
        repeat (FT + 3) step(1'b1, 1'b1);
        // en low exactly at the last pixel: straight to idle
        run_to(1'b1, FT - 1);
        repeat (4) step(1'b1, 1'b0);
        // single-cycle en pulse from idle runs a full frame
        step(1'b1, 1'b1);
        repeat (FT + 3) step(1'b1, 1'b0);
        // STOP reaching the final wrap with en=1: no gap
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        run_to(1'b0, FT - 1);
        repeat (FT + 2) step(1'b1, 1'b1);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
